mdu_iter: RTL and testbench

- Multiply/divide unit for the datapath; owns the HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency; services MTHI/MTLO/MFHI/MFLO.
- Sits directly upstream of the register write-back source select: MDUOut is one of the candidate write-back data inputs.
- busy goes to the controller for stall generation.

---
 rtl/mdu_iter_pkg.sv | 42 ++++
 rtl/mdu_calc.sv | 85 ++++++++
 rtl/mdu_iter.sv | 111 +++++++++++
 tb/tb_mdu_iter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_iter_pkg.sv
// Shared MDU definitions: operation codes, default latencies and op-class helpers.
// Optional MADD/MADDU support is enabled by defining MDU_MADD_EN.
package mdu_iter_pkg;

  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;
  localparam logic [3:0] MDU_MADD  = 4'd9;
  localparam logic [3:0] MDU_MADDU = 4'd10;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_long_op(input logic [3:0] op);
    logic res;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: res = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU:                    res = 1'b1;
`endif
      default:                                res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU arithmetic: products, quotients/remainders and (with MDU_MADD_EN)
// multiply-accumulate onto the current HI/LO. write_en is low for divide by zero.
module mdu_calc
  import mdu_iter_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] next_hi,
  output logic [31:0] next_lo,
  output logic        write_en
);

  logic [63:0] sprod_s;
  logic [63:0] uprod_s;
  logic [31:0] b_safe_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;
  logic [31:0] mq_s;
  logic [31:0] mr_s;
  logic [31:0] sq_s;
  logic [31:0] sr_s;

  // Sign-extended operands give the signed product modulo 2^64.
  assign sprod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod_s = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
  assign b_safe_s = (b == 32'd0) ? 32'd1 : b;
  assign abs_a_s  = a[31] ? (~a + 32'd1) : a;
  assign abs_b_s  = b_safe_s[31] ? (~b_safe_s + 32'd1) : b_safe_s;
  assign uq_s     = a / b_safe_s;
  assign ur_s     = a % b_safe_s;
  assign mq_s     = abs_a_s / abs_b_s;
  assign mr_s     = abs_a_s % abs_b_s;
  assign sq_s     = (a[31] ^ b_safe_s[31]) ? (~mq_s + 32'd1) : mq_s;
  assign sr_s     = a[31] ? (~mr_s + 32'd1) : mr_s;

  // Result select per operation.
  always_comb begin
    next_hi  = hi;
    next_lo  = lo;
    write_en = 1'b0;
    case (op)
      MDU_MULT: begin
        {next_hi, next_lo} = sprod_s;
        write_en           = 1'b1;
      end
      MDU_MULTU: begin
        {next_hi, next_lo} = uprod_s;
        write_en           = 1'b1;
      end
      MDU_DIV: begin
        next_lo  = sq_s;
        next_hi  = sr_s;
        write_en = (b != 32'd0);
      end
      MDU_DIVU: begin
        next_lo  = uq_s;
        next_hi  = ur_s;
        write_en = (b != 32'd0);
      end
`ifdef MDU_MADD_EN
      MDU_MADD: begin
        {next_hi, next_lo} = {hi, lo} + sprod_s;
        write_en           = 1'b1;
      end
      MDU_MADDU: begin
        {next_hi, next_lo} = {hi, lo} + uprod_s;
        write_en           = 1'b1;
      end
`endif
      default: begin
        next_hi  = hi;
        next_lo  = lo;
        write_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit owning HI/LO; result is staged in pending registers
// and committed when the latency counter expires. Define MDU_MADD_EN for MADD/MADDU.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [31:0]      pend_hi_r;
  logic [31:0]      pend_lo_r;
  logic             pend_we_r;

  logic [31:0]      calc_hi_s;
  logic [31:0]      calc_lo_s;
  logic             calc_we_s;
  logic             accept_s;
  logic [CNT_W-1:0] load_cnt_s;

  mdu_calc u_calc (
    .op       (MDUOp),
    .a        (A),
    .b        (B),
    .hi       (hi_r),
    .lo       (lo_r),
    .next_hi  (calc_hi_s),
    .next_lo  (calc_lo_s),
    .write_en (calc_we_s)
  );

  assign accept_s   = valid & ~busy_r & is_long_op(MDUOp);
  assign load_cnt_s = is_div_op(MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  assign busy   = busy_r;
  assign HI     = hi_r;
  assign LO     = lo_r;
  assign MDUOut = (MDUOp == MDU_MFLO) ? lo_r : hi_r;

  // Accept/latency FSM with HI/LO commit and idle-time MTHI/MTLO writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      busy_r    <= 1'b0;
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
      pend_we_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            pend_hi_r <= calc_hi_s;
            pend_lo_r <= calc_lo_s;
            pend_we_r <= calc_we_s;
            cnt_r     <= load_cnt_s;
            busy_r    <= 1'b1;
            state_r   <= ST_BUSY;
          end else if (valid && (MDUOp == MDU_MTHI)) begin
            hi_r <= A;
          end else if (valid && (MDUOp == MDU_MTLO)) begin
            lo_r <= A;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_BUSY: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
            if (pend_we_r) begin
              hi_r <= pend_hi_r;
              lo_r <= pend_lo_r;
            end else begin
              hi_r <= hi_r;
            end
          end else begin
            busy_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed table, multi-cycle corner sequences and
// random ops against a plain-arithmetic HI/LO model. Honours MDU_MADD_EN.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  MDUOp = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI, LO, MDUOut;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_iter dut (
    .clk(clk), .reset(reset), .valid(valid), .MDUOp(MDUOp), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO), .MDUOut(MDUOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_n;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: architectural effect of one accepted op; returns busy length.
  function automatic int model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint unsigned up;
    longint q, r;
    case (op)
      4'd1: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = p; return 5; end
      4'd2: begin up = longint'({32'd0, a}) * longint'({32'd0, b}); {m_hi, m_lo} = up; return 5; end
      4'd3: begin
        if (b != 32'd0) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          m_lo = q[31:0]; m_hi = r[31:0];
        end
        return 10;
      end
      4'd4: begin
        if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
        return 10;
      end
      4'd5: begin m_hi = a; return 0; end
      4'd6: begin m_lo = a; return 0; end
`ifdef MDU_MADD_EN
      4'd9: begin p = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = {m_hi, m_lo} + p; return 5; end
      4'd10: begin up = longint'({32'd0, a}) * longint'({32'd0, b}); {m_hi, m_lo} = {m_hi, m_lo} + up; return 5; end
`endif
      default: return 0;
    endcase
  endfunction

  // Counts busy cycles from the current negedge; also checks HI/LO hold while busy.
  task automatic wait_idle(input logic [31:0] old_hi, input logic [31:0] old_lo, output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      chk("hold_hilo", {HI, LO}, {old_hi, old_lo});
      cnt++;
      @(negedge clk);
    end
    if (cnt >= 40) chk("busy_timeout", 64'(cnt), 64'd0);
  endtask

  task automatic chk_out(input string tag);
    MDUOp = MDU_MFLO; #1;
    chk({tag, "_mflo"}, MDUOut, m_lo);
    MDUOp = MDU_MFHI; #1;
    chk({tag, "_mfhi"}, MDUOut, m_hi);
    MDUOp = MDU_NOP;
  endtask

  // Issues one op at a negedge, waits for completion, compares busy length and HI/LO.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_n);
    int cnt;
    valid = 1'b1; MDUOp = op; A = a; B = b;
    @(negedge clk);
    valid = 1'b0; MDUOp = MDU_NOP;
    wait_idle(old_hi, old_lo, cnt);
    chk({name, "_busy"}, 64'(cnt), 64'(exp_n));
    chk({name, "_hilo"}, {HI, LO}, {exp_hi, exp_lo});
  endtask

  vec_t vecs[$];

  initial begin
    int n, cnt;
    logic [31:0] oh, ol;
    logic [3:0] rop;
    logic [31:0] ra, rb;

    vecs.push_back('{4'd1,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5});
    vecs.push_back('{4'd2,  32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5});
    vecs.push_back('{4'd3,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vecs.push_back('{4'd4,  32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vecs.push_back('{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10});
    vecs.push_back('{4'd5,  32'h12345678, 32'd0,        32'h12345678, 32'h80000000, 0});
    vecs.push_back('{4'd6,  32'h0000CAFE, 32'd0,        32'h12345678, 32'h0000CAFE, 0});
    vecs.push_back('{4'd12, 32'd1,        32'd1,        32'h12345678, 32'h0000CAFE, 0});
    vecs.push_back('{4'd5,  32'd0,        32'd0,        32'h00000000, 32'h0000CAFE, 0});
    vecs.push_back('{4'd6,  32'hFFFFFFFF, 32'd0,        32'h00000000, 32'hFFFFFFFF, 0});
`ifdef MDU_MADD_EN
    vecs.push_back('{4'd10, 32'd1,        32'd1,        32'h00000001, 32'h00000000, 5});
`else
    vecs.push_back('{4'd10, 32'd1,        32'd1,        32'h00000000, 32'hFFFFFFFF, 0});
`endif

    // Reset state
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      oh = m_hi; ol = m_lo;
      n = model_apply(vecs[i].op, vecs[i].a, vecs[i].b);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, oh, ol,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_n);
      chk_out($sformatf("vec%0d", i));
    end

    // MTLO during MULT busy is ignored
    oh = m_hi; ol = m_lo;
    valid = 1'b1; MDUOp = MDU_MULT; A = 32'h00010000; B = 32'h00010000;
    @(negedge clk);
    valid = 1'b0; MDUOp = MDU_NOP;
    @(negedge clk);
    valid = 1'b1; MDUOp = MDU_MTLO; A = 32'h55;
    @(negedge clk);
    valid = 1'b0; MDUOp = MDU_NOP;
    wait_idle(oh, ol, cnt);
    chk("mtlo_busy_len", 64'(cnt + 2), 64'd5);
    chk("mtlo_ignored", {HI, LO}, {32'd1, 32'd0});
    m_hi = 32'd1; m_lo = 32'd0;

    // DIV presented on MULT busy cycles 1..4 is dropped, then back-to-back DIV
    oh = m_hi; ol = m_lo;
    valid = 1'b1; MDUOp = MDU_MULT; A = 32'd7; B = 32'd6;
    @(negedge clk);
    MDUOp = MDU_DIV; A = 32'd100; B = 32'd7;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (busy === 1'b1) cnt++;
      @(negedge clk);
    end
    valid = 1'b0; MDUOp = MDU_NOP;
    while (busy === 1'b1 && cnt < 40) begin cnt++; @(negedge clk); end
    chk("drop_busy_len", 64'(cnt), 64'd5);
    chk("drop_hilo", {HI, LO}, {32'd0, 32'd42});
    m_hi = 32'd0; m_lo = 32'd42;
    n = model_apply(MDU_DIV, 32'd100, 32'd7);
    run_op("b2b_div", MDU_DIV, 32'd100, 32'd7, 32'd0, 32'd42, 32'd2, 32'd14, n);

    // Reset asserted in cycle 4 of a DIV aborts it
    valid = 1'b1; MDUOp = MDU_DIV; A = 32'd1000; B = 32'd3;
    @(negedge clk);
    valid = 1'b0; MDUOp = MDU_NOP;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_nocommit_busy", 64'(busy), 64'd0);
    chk("abort_nocommit_hilo", {HI, LO}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    // Random ops against the model
    for (int k = 0; k < 60; k++) begin
      rop = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 5) == 0) rb = 32'hFFFFFFFF;
      oh = m_hi; ol = m_lo;
      n = model_apply(rop, ra, rb);
      run_op($sformatf("rnd%0d_op%0d", k, rop), rop, ra, rb, oh, ol, m_hi, m_lo, n);
    end
    chk_out("rnd_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
